// File: rtl/input_process_uart.sv
// Receive-side frame decoder: SYNC 0xAA, LEN, LEN x 16-bit words, trailer.
// A validated message is held in a word buffer until the host drains it with RD.
module input_process_uart #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int DEPTH_LOG2     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        RD,
    output logic        GOT_FULL_MESSAGE,
    output logic [15:0] FIFO_Q,
    output logic [7:0]  MSG_LEN,
    output logic        PARITY_OUT,
    output logic        FRAME_ERR,
    output logic        OVERRUN
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, GET_LEN, DATA_HI, DATA_LO, TRAIL, PENDING} state_t;

    state_t                state, state_next;
    logic [7:0]            len_q;
    logic [7:0]            word_cnt;
    logic [7:0]            hi_q;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0]         tmo_cnt;
    logic [15:0]           mem [2**DEPTH_LOG2];

    logic byte_fire, active, expired;
    logic flush, frame_err_set, overrun_set, wr_en, rd_fire, accept_trailer;

    // Bytes are never back-pressured: the UART core cannot buffer them.
    assign rx_ready         = ~RST;
    assign byte_fire        = rx_valid && rx_ready;
    assign GOT_FULL_MESSAGE = (state == PENDING);
    assign active           = (state == GET_LEN) || (state == DATA_HI) ||
                              (state == DATA_LO) || (state == TRAIL);
    assign expired          = active && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_next     = state;
        flush          = 1'b0;
        frame_err_set  = 1'b0;
        overrun_set    = 1'b0;
        wr_en          = 1'b0;
        rd_fire        = 1'b0;
        accept_trailer = 1'b0;
        // Timeout expiry takes priority over any byte arriving in the same cycle.
        if (expired) begin
            state_next    = IDLE;
            flush         = 1'b1;
            frame_err_set = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_fire && rx_data == 8'hAA) state_next = GET_LEN;
                end
                GET_LEN: begin
                    if (byte_fire) begin
                        if (rx_data == 8'h00) begin
                            state_next    = IDLE;
                            flush         = 1'b1;
                            frame_err_set = 1'b1;
                        end else begin
                            state_next = DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (byte_fire) state_next = DATA_LO;
                end
                DATA_LO: begin
                    if (byte_fire) begin
                        wr_en      = 1'b1;
                        state_next = (word_cnt + 8'd1 == len_q) ? TRAIL : DATA_HI;
                    end
                end
                TRAIL: begin
                    if (byte_fire) begin
                        if (rx_data[7:1] == 7'd0) begin
                            accept_trailer = 1'b1;
                            state_next     = PENDING;
                        end else begin
                            state_next    = IDLE;
                            flush         = 1'b1;
                            frame_err_set = 1'b1;
                        end
                    end
                end
                PENDING: begin
                    overrun_set = byte_fire;
                    if (RD && rd_ptr != DEPTH_LOG2'(MSG_LEN)) begin
                        rd_fire = 1'b1;
                        if (rd_ptr == DEPTH_LOG2'(MSG_LEN - 8'd1)) begin
                            state_next = IDLE;
                            flush      = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            len_q      <= '0;
            word_cnt   <= '0;
            hi_q       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tmo_cnt    <= '0;
            FIFO_Q     <= '0;
            MSG_LEN    <= '0;
            PARITY_OUT <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state     <= state_next;
            FRAME_ERR <= frame_err_set;
            OVERRUN   <= overrun_set;
            tmo_cnt   <= (active && !byte_fire && !expired) ? tmo_cnt + TW'(1) : '0;
            if (state == GET_LEN && state_next == DATA_HI) begin
                len_q    <= rx_data;
                word_cnt <= '0;
            end
            if (state == DATA_HI && state_next == DATA_LO) hi_q <= rx_data;
            if (wr_en) begin
                wr_ptr   <= wr_ptr + DEPTH_LOG2'(1);
                word_cnt <= word_cnt + 8'd1;
            end
            if (accept_trailer) begin
                MSG_LEN    <= len_q;
                PARITY_OUT <= rx_data[0];
            end
            if (rd_fire) begin
                FIFO_Q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                word_cnt <= '0;
            end
        end
    end

    // Write port kept free of reset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= {hi_q, rx_data};
    end
endmodule

// File: tb/tb_input_process_uart.sv
// Self-checking bench for input_process_uart: directed frames plus a random
// byte stream, compared every cycle against a frame-level reference model.
module tb_input_process_uart;
    localparam int TMO = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        RD = 1'b0;
    logic        GOT_FULL_MESSAGE;
    logic [15:0] FIFO_Q;
    logic [7:0]  MSG_LEN;
    logic        PARITY_OUT;
    logic        FRAME_ERR;
    logic        OVERRUN;

    always #5 CLK = ~CLK;

    input_process_uart #(.TIMEOUT_CYCLES(TMO), .DEPTH_LOG2(8)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .RD(RD), .GOT_FULL_MESSAGE(GOT_FULL_MESSAGE),
        .FIFO_Q(FIFO_Q), .MSG_LEN(MSG_LEN), .PARITY_OUT(PARITY_OUT),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: the partial frame as raw bytes, and the held message.
    logic [7:0]  frame_q[$];
    logic [15:0] m_words[$];
    bit          m_pending;
    int          m_rd_idx;
    int          m_idle;
    logic [15:0] m_q;
    logic [7:0]  m_msg_len;
    logic        m_parity;
    bit          m_err, m_ovr;

    logic [7:0]  stim_q[$];
    logic [7:0]  rnd_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        frame_q.delete();
        m_words.delete();
        m_pending = 0;
        m_rd_idx  = 0;
        m_idle    = 0;
        m_q       = '0;
        m_msg_len = '0;
        m_parity  = 1'b0;
        m_err     = 0;
        m_ovr     = 0;
    endfunction

    function automatic void modelStep(input bit v, input logic [7:0] d, input bit rd);
        int n;
        m_err = 0;
        m_ovr = 0;
        if (m_pending) begin
            if (v) m_ovr = 1;
            if (rd && m_rd_idx < m_words.size()) begin
                m_q = m_words[m_rd_idx];
                m_rd_idx++;
                if (m_rd_idx == m_words.size()) m_pending = 0;
            end
        end else if (frame_q.size() == 0) begin
            if (v && d == 8'hAA) begin
                frame_q.push_back(d);
                m_idle = 0;
            end
        end else if (m_idle == TMO - 1) begin
            frame_q.delete();
            m_err  = 1;
            m_idle = 0;
        end else if (v) begin
            frame_q.push_back(d);
            m_idle = 0;
            n = int'(frame_q[1]);
            if (frame_q.size() == 2 && d == 8'h00) begin
                m_err = 1;
                frame_q.delete();
            end else if (frame_q.size() > 2 && frame_q.size() == 3 + 2 * n) begin
                if (d[7:1] != 7'd0) begin
                    m_err = 1;
                end else begin
                    m_pending = 1;
                    m_msg_len = frame_q[1];
                    m_parity  = d[0];
                    m_rd_idx  = 0;
                    m_words.delete();
                    for (int i = 0; i < n; i++) m_words.push_back({frame_q[2 + 2 * i], frame_q[3 + 2 * i]});
                end
                frame_q.delete();
            end
        end else begin
            m_idle++;
        end
    endfunction

    task automatic compareAll();
        checkOutput("rx_ready", rx_ready, 1);
        checkOutput("frame_err", FRAME_ERR, m_err);
        checkOutput("overrun", OVERRUN, m_ovr);
        checkOutput("got_full", GOT_FULL_MESSAGE, m_pending);
        checkOutput("fifo_q", FIFO_Q, m_q);
        checkOutput("msg_len", MSG_LEN, m_msg_len);
        checkOutput("parity", PARITY_OUT, m_parity);
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit rd);
        rx_valid = v;
        rx_data  = d;
        RD       = rd;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        RD       = 1'b0;
        modelStep(v, d, rd);
        compareAll();
    endtask

    task automatic doReset();
        RST      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(posedge CLK);
        #1;
        modelReset();
        checkOutput("rst_rx_ready", rx_ready, 0);
        checkOutput("rst_got_full", GOT_FULL_MESSAGE, 0);
        checkOutput("rst_fifo_q", FIFO_Q, 0);
        checkOutput("rst_msg_len", MSG_LEN, 0);
        checkOutput("rst_parity", PARITY_OUT, 0);
        checkOutput("rst_frame_err", FRAME_ERR, 0);
        checkOutput("rst_overrun", OVERRUN, 0);
        RST      = 1'b0;
        rx_valid = 1'b0;
        #1;
        checkOutput("post_rst_rx_ready", rx_ready, 1);
    endtask

    task automatic sendStim();
        foreach (stim_q[i]) applyStimulus(1, stim_q[i], 0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 8'h00, 0);
    endtask

    task automatic readWords(input int n);
        repeat (n) applyStimulus(0, 8'h00, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall;
        bit v, rd;
        logic [7:0] d;
        int len;

        modelReset();
        doReset();

        $display("[TB] basic two-word frame");
        stim_q = {8'hAA, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h01};
        sendStim();
        checkOutput("p1_got_full", GOT_FULL_MESSAGE, 1);
        checkOutput("p1_msg_len", MSG_LEN, 2);
        checkOutput("p1_parity", PARITY_OUT, 1);
        readWords(1);
        checkOutput("p1_word0", FIFO_Q, 16'h1234);
        readWords(1);
        checkOutput("p1_word1", FIFO_Q, 16'hABCD);
        checkOutput("p1_got_full_low", GOT_FULL_MESSAGE, 0);

        $display("[TB] zero length then one-word frame");
        stim_q = {8'hAA, 8'h00};
        sendStim();
        checkOutput("p2_len0_err", FRAME_ERR, 1);
        stim_q = {8'hAA, 8'h01, 8'h00, 8'hFF, 8'h00};
        sendStim();
        checkOutput("p2_parity", PARITY_OUT, 0);
        readWords(1);
        checkOutput("p2_word0", FIFO_Q, 16'h00FF);

        $display("[TB] bad trailer");
        stim_q = {8'hAA, 8'h01, 8'h55, 8'h66, 8'h03};
        sendStim();
        checkOutput("p3_trailer_err", FRAME_ERR, 1);
        checkOutput("p3_no_msg", GOT_FULL_MESSAGE, 0);
        stim_q = {8'hAA, 8'h01, 8'h77, 8'h88, 8'h00};
        sendStim();
        readWords(1);
        checkOutput("p3_word0", FIFO_Q, 16'h7788);

        $display("[TB] timeout mid-frame");
        stim_q = {8'hAA, 8'h03, 8'h11};
        sendStim();
        idleCycles(TMO - 1);
        checkOutput("p4_before_expiry", FRAME_ERR, 0);
        idleCycles(1);
        checkOutput("p4_expiry", FRAME_ERR, 1);
        stim_q = {8'hAA, 8'h01, 8'h21, 8'h43, 8'h01};
        sendStim();
        readWords(1);
        checkOutput("p4_word0", FIFO_Q, 16'h2143);

        $display("[TB] timeout coinciding with a byte");
        stim_q = {8'hAA, 8'h02, 8'h11};
        sendStim();
        idleCycles(TMO - 1);
        applyStimulus(1, 8'hAA, 0);
        checkOutput("p4b_expiry_wins", FRAME_ERR, 1);
        stim_q = {8'h01, 8'h02, 8'h03, 8'h00};
        sendStim();
        checkOutput("p4b_no_msg", GOT_FULL_MESSAGE, 0);

        $display("[TB] overrun while pending");
        stim_q = {8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
        sendStim();
        stim_q = {8'hAA, 8'h09, 8'h33};
        sendStim();
        checkOutput("p5_overrun", OVERRUN, 1);
        readWords(2);
        checkOutput("p5_word1", FIFO_Q, 16'h0304);
        applyStimulus(1, 8'h5A, 1);
        checkOutput("p5_last_overrun", OVERRUN, 1);
        checkOutput("p5_word2", FIFO_Q, 16'h0506);
        checkOutput("p5_done", GOT_FULL_MESSAGE, 0);

        $display("[TB] maximum length frame");
        stim_q = {8'hAA, 8'hFF};
        for (int i = 0; i < 255; i++) begin
            stim_q.push_back(8'h00);
            stim_q.push_back(8'(i));
        end
        stim_q.push_back(8'h00);
        sendStim();
        checkOutput("p6_msg_len", MSG_LEN, 255);
        readWords(255);
        checkOutput("p6_last", FIFO_Q, 16'h00FE);
        readWords(1);
        checkOutput("p6_hold", FIFO_Q, 16'h00FE);

        $display("[TB] reset mid-frame");
        stim_q = {8'hAA, 8'h02, 8'h12};
        sendStim();
        doReset();
        stim_q = {8'hAA, 8'h01, 8'hBE, 8'hEF, 8'h01};
        sendStim();
        readWords(1);
        checkOutput("p7_word0", FIFO_Q, 16'hBEEF);

        $display("[TB] random stream");
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rnd_q.size() == 0) begin
                len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
                rnd_q.push_back(8'hAA);
                rnd_q.push_back(8'(len));
                for (int i = 0; i < 2 * len; i++) rnd_q.push_back(8'($urandom));
                if (len != 0)
                    rnd_q.push_back(($urandom_range(0, 6) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 199) == 0) stall = TMO - 2 + int'($urandom_range(0, 3));
            if (stall > 0) begin
                stall--;
                v = 0;
            end else if (m_pending) begin
                v = ($urandom_range(0, 9) == 0);
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            rd = m_pending ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            d  = v ? rnd_q.pop_front() : 8'($urandom);
            applyStimulus(v, d, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
